// File: rtl/id_ex_stage_buf_if.sv
// ============================================================================
// Module   : id_ex_stage_buf_if
// Brief    : Handshake bus between decode, the ID/EX buffer and execute.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_ex_stage_buf_if #(
  parameter int DATA_W = 288,
  parameter int CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage_buf.sv
// ============================================================================
// Module   : id_ex_stage_buf
// Brief    : ID/EX boundary register with 2-entry skid buffer, flush,
//            control bubble masking and a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage_buf #(
  parameter int DATA_W = 288,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_stage_buf_if.slave bus,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic       w_accept;
  logic       w_deliver;
  logic [1:0] w_state;

  assign w_state   = {main_v_q, skid_v_q};
  assign w_accept  = bus.in_valid & ~skid_v_q;
  assign w_deliver = main_v_q & bus.out_ready;

  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    case (w_state)
      ST_EMPTY: begin
        if (w_accept) begin
          main_v_d    = 1'b1;
          main_data_d = bus.in_data;
          main_ctrl_d = bus.in_ctrl;
        end
      end
      ST_ONE: begin
        if (w_accept && w_deliver) begin
          main_data_d = bus.in_data;
          main_ctrl_d = bus.in_ctrl;
        end else if (w_accept) begin
          skid_v_d    = 1'b1;
          skid_data_d = bus.in_data;
          skid_ctrl_d = bus.in_ctrl;
        end else if (w_deliver) begin
          main_v_d = 1'b0;
        end
      end
      ST_FULL: begin
        if (w_deliver) begin
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          skid_v_d    = 1'b0;
        end
      end
      default: begin
        // skid-only is unreachable; recover to EMPTY
        main_v_d = 1'b0;
        skid_v_d = 1'b0;
      end
    endcase

    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (main_v_q && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.in_ready  = ~skid_v_q;
  assign bus.out_valid = main_v_q;
  assign bus.out_data  = main_data_q;
  // Invalid slot must look like a NOP to execute
  assign bus.out_ctrl  = main_v_q ? main_ctrl_q : '0;
  assign stall_cnt     = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage_buf.sv
// Bench for id_ex_stage_buf: directed literal checks plus a randomized run
// against a queue-based model (one 16-bit and one 4-bit counter instance).
`default_nettype none

module tb_id_ex_stage_buf;

  localparam int DW = 288;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, out_ready, flush, cnt_clr;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic [15:0]   stall16;
  logic [3:0]    stall4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) bus16 ();
  id_ex_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) bus4 ();

  assign bus16.in_valid  = in_valid;
  assign bus16.in_data   = in_data;
  assign bus16.in_ctrl   = in_ctrl;
  assign bus16.out_ready = out_ready;
  assign bus4.in_valid   = in_valid;
  assign bus4.in_data    = in_data;
  assign bus4.in_ctrl    = in_ctrl;
  assign bus4.out_ready  = out_ready;

  id_ex_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16), .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(stall16)
  );

  id_ex_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(stall4)
  );

  // ---------------- behavioural model: a FIFO of depth 2 ----------------
  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t        mq[$];
  int unsigned mcnt16, mcnt4;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mcnt16 <= 0;
      mcnt4  <= 0;
    end else begin
      if (cnt_clr) begin
        mcnt16 <= 0;
        mcnt4  <= 0;
      end else if (mq.size() > 0 && !out_ready) begin
        if (mcnt16 < 65535) mcnt16 <= mcnt16 + 1;
        if (mcnt4 < 15)     mcnt4  <= mcnt4 + 1;
      end
      if (flush) begin
        mq.delete();
      end else if (mq.size() == 0) begin
        if (in_valid) mq.push_back('{in_data, in_ctrl});
      end else begin
        if (mq.size() < 2 && in_valid) mq.push_back('{in_data, in_ctrl});
        if (out_ready) void'(mq.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    chk("m_out_valid", DW'(bus16.out_valid), DW'(mq.size() > 0));
    chk("m_in_ready",  DW'(bus16.in_ready),  DW'(mq.size() < 2));
    chk("m4_out_valid", DW'(bus4.out_valid), DW'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("m_out_data", bus16.out_data, mq[0].d);
      chk("m_out_ctrl", DW'(bus16.out_ctrl), DW'(mq[0].c));
    end else begin
      chk("m_bubble_ctrl",  DW'(bus16.out_ctrl), '0);
      chk("m4_bubble_ctrl", DW'(bus4.out_ctrl),  '0);
    end
    chk("m_stall16", DW'(stall16), DW'(mcnt16));
    chk("m_stall4",  DW'(stall4),  DW'(mcnt4));
  end

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] mk(input int unsigned i);
    logic [31:0] w;
    w = i ^ 32'hC0DE_0000;
    return {9{w}};
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int k = 0; k < 9; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 0; out_ready = 0; flush = 0; cnt_clr = 0;
    in_data = '0; in_ctrl = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_in_ready",  DW'(bus16.in_ready),  DW'(1));
    chk("rst_out_valid", DW'(bus16.out_valid), '0);
    chk("rst_out_ctrl",  DW'(bus16.out_ctrl),  '0);
    chk("rst_stall",     DW'(stall16),         '0);

    // first-entry latency and full-throughput stream
    in_valid = 1; in_ctrl = 8'h5A; in_data = mk(100); out_ready = 1;
    step();
    chk("t1_valid", DW'(bus16.out_valid), DW'(1));
    chk("t1_ctrl",  DW'(bus16.out_ctrl),  DW'(8'h5A));
    chk("t1_data",  bus16.out_data,       mk(100));
    for (int i = 0; i < 10; i++) begin
      in_data = mk(i); in_ctrl = 8'(i + 1);
      step();
      chk("stream_data", bus16.out_data, mk(i));
      chk("stream_ctrl", DW'(bus16.out_ctrl), DW'(i + 1));
    end
    in_valid = 0;
    step();
    chk("stream_drained", DW'(bus16.out_valid), '0);

    // backpressure fills the skid, then drains in order
    out_ready = 0; in_valid = 1; in_data = mk(201); in_ctrl = 8'h11;
    step();
    in_data = mk(202); in_ctrl = 8'h12;
    step();
    chk("bp_in_ready0", DW'(bus16.in_ready), '0);
    chk("bp_model_full", DW'(mq.size()), DW'(2));
    in_data = mk(203); in_ctrl = 8'h13;
    step();
    chk("bp_hold_d1", bus16.out_data, mk(201));
    out_ready = 1;
    step();
    chk("bp_d2", bus16.out_data, mk(202));
    chk("bp_ready1", DW'(bus16.in_ready), DW'(1));
    step();
    chk("bp_d3", bus16.out_data, mk(203));
    in_valid = 0;
    step();
    chk("bp_empty", DW'(bus16.out_valid), '0);

    // flush in FULL discards the simultaneous accept
    out_ready = 0; in_valid = 1; in_data = mk(301); in_ctrl = 8'h21;
    step();
    in_data = mk(302); in_ctrl = 8'h22;
    step();
    flush = 1; in_data = mk(303); in_ctrl = 8'h23;
    step();
    flush = 0; in_valid = 0;
    chk("fl_valid", DW'(bus16.out_valid), '0);
    chk("fl_ctrl",  DW'(bus16.out_ctrl),  '0);
    chk("fl_ready", DW'(bus16.in_ready),  DW'(1));
    out_ready = 1;
    step(); step();
    chk("fl_no_d3", DW'(bus16.out_valid), '0);

    // stall counter: count, clear, saturate
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    chk("sc_clr0", DW'(stall16), '0);
    out_ready = 0; in_valid = 1; in_data = mk(401); in_ctrl = 8'h31;
    step();
    in_valid = 0;
    for (int i = 0; i < 5; i++) step();
    chk("sc_five",  DW'(stall16), DW'(5));
    chk("sc_five4", DW'(stall4),  DW'(5));
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    chk("sc_clr", DW'(stall16), '0);
    step();
    chk("sc_one", DW'(stall16), DW'(1));
    for (int i = 0; i < 20; i++) step();
    chk("sc_21",  DW'(stall16), DW'(21));
    chk("sc_sat", DW'(stall4),  DW'(15));

    // asynchronous reset while FULL
    in_valid = 1; in_data = mk(501); in_ctrl = 8'h41;
    step();
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("ar_valid",   DW'(bus16.out_valid), '0);
    chk("ar_ctrl",    DW'(bus16.out_ctrl),  '0);
    chk("ar_stall16", DW'(stall16),         '0);
    chk("ar_stall4",  DW'(stall4),          '0);
    step();
    rst = 1'b0;
    step();
    chk("ar_ready", DW'(bus16.in_ready), DW'(1));

    // randomized traffic against the model
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      cnt_clr   = ($urandom_range(0, 199) == 0);
      in_data   = rnd();
      in_ctrl   = 8'($urandom);
      step();
    end
    in_valid = 0; flush = 0; cnt_clr = 0; out_ready = 1;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
